// File: rtl/cache_fill_fsm_pkg.sv
// Shared cache definitions: block geometry, the offset mask and the fill FSM state encoding.
// Latency: none (declarations only).
// Backpressure: none.
package cache_fill_fsm_pkg;

    localparam int WORDS_PER_BLOCK = 8;
    localparam int OFF_W           = $clog2(WORDS_PER_BLOCK);

    // Clears the byte offset inside a 16-byte block.
    localparam logic [15:0] BLOCK_MASK = 16'hFFF0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_t;

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Saturating up-counter with synchronous clear/enable; done flags the terminal count.
// Latency: count updates on the edge after en; done is combinational from the count.
// Backpressure: none; en is ignored once the count has saturated.
module fill_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             done
);

    assign done = (cnt == WIDTH'(MAX));

    // Clear has priority over counting; the count holds once it reaches MAX.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !done) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: fetches an aligned 8-word block, one request per cycle, and steers returns into the arrays.
// Latency: first request in the cycle after the miss is sampled; tag write in the cycle of the 8th returned word.
// Backpressure: none from memory; fsm_busy stalls the CPU pipeline for the whole fill.
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [OFF_W-1:0]  fill_word_sel,
    output logic              write_tag_array
);

    // Request counter needs one extra bit so it can park at WORDS_PER_BLOCK.
    localparam int REQ_W = OFF_W + 1;

    fill_state_t       state;
    logic [ADDR_W-1:0] base;
    logic [REQ_W-1:0]  req_cnt;
    logic              req_done;
    logic [OFF_W-1:0]  ret_cnt;
    logic              ret_last;
    logic              in_fill;

    assign in_fill = (state == ST_FILL);

    // Both counters sit at zero whenever the FSM is idle, so a new fill always starts clean.
    fill_counter #(
        .WIDTH (REQ_W),
        .MAX   (WORDS_PER_BLOCK)
    ) u_req_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (!in_fill),
        .en   (in_fill),
        .cnt  (req_cnt),
        .done (req_done)
    );

    // Return counter parks at the last word; its done flag marks the final return of the block.
    fill_counter #(
        .WIDTH (OFF_W),
        .MAX   (WORDS_PER_BLOCK - 1)
    ) u_ret_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (!in_fill),
        .en   (write_data_array),
        .cnt  (ret_cnt),
        .done (ret_last)
    );

    // Latch the aligned block address on a miss; leave FILL on the last returned word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            base  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (miss_detected) begin
                        base  <= miss_address & ADDR_W'(BLOCK_MASK);
                        state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (memory_data_valid && ret_last) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Request side: one word address per cycle until all eight have been issued.
    // The block is aligned, so adding the word offset never carries past bit 3.
    assign fsm_busy       = in_fill;
    assign mem_read_en    = in_fill && !req_done;
    assign memory_address = mem_read_en ? (base + (ADDR_W'(req_cnt) << 1)) : '0;

    // Return side: writes line up with the returned word in the same cycle.
    assign write_data_array = in_fill && memory_data_valid;
    assign fill_word_sel    = write_data_array ? ret_cnt : '0;
    assign write_tag_array  = write_data_array && ret_last;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: table of back-to-back fills plus a reset-mid-fill sequence.
// Latency: a 4-cycle memory model answers each request 3 cycles later (or late and gapped in irregular mode).
// Backpressure: none; every check runs inside bounded cycle loops.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        mem_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  fill_word_sel;
    logic        write_tag_array;

    always #5 clk = ~clk;

    cache_fill_fsm #(.ADDR_W(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .mem_read_en       (mem_read_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_word_sel     (fill_word_sel),
        .write_tag_array   (write_tag_array)
    );

    typedef struct {
        logic [15:0] miss_addr;
        bit          irregular;
        int          mid_rel;      // fill-relative cycle carrying an extra miss to 0x0400 (0 = none)
        logic [15:0] exp_base;
        int          exp_busy;     // 0 = do not check timing
        int          exp_wr_first;
        int          exp_tag_rel;
    } vec_t;

    vec_t tbl [7];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int rel   = 0;
    bit irregular = 1'b0;

    logic [15:0] exp_addr_q [$];
    int          exp_sel_q  [$];
    int          mem_q      [$];

    int busy_cnt;
    int req_first;
    int wr_first;
    int tag_rel;
    bit tag_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d, rel %0d)", name, act, exp, cyc, rel);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got 0x%0h, required nothing (cycle %0d, rel %0d)", name, act, cyc, rel);
    endtask

    // One clock cycle: memory model drives valid, outputs are scored, then advance past the next edge.
    task automatic cycle_check();
        cyc++;
        memory_data_valid = 1'b0;
        if (mem_q.size() > 0 && cyc >= mem_q[0] && (!irregular || (cyc % 3) == 0)) begin
            memory_data_valid = 1'b1;
            void'(mem_q.pop_front());
        end
        #1;
        if (mem_read_en === 1'b1) begin
            mem_q.push_back(cyc + (irregular ? 8 : 3));
            if (req_first < 0) req_first = rel;
            if (exp_addr_q.size() == 0) flag("unexpected_request", {16'h0, memory_address});
            else chk("req_addr", {16'h0, memory_address}, {16'h0, exp_addr_q.pop_front()});
        end
        if (write_data_array === 1'b1) begin
            if (exp_sel_q.size() == 0) begin
                flag("unexpected_write", {29'h0, fill_word_sel});
            end else begin
                int s;
                s = exp_sel_q.pop_front();
                chk("fill_word_sel", {29'h0, fill_word_sel}, s);
                chk("write_tag_array", {31'h0, write_tag_array}, {31'h0, (s == 7)});
                if (wr_first < 0) wr_first = rel;
                if (write_tag_array === 1'b1) begin
                    tag_seen = 1'b1;
                    tag_rel  = rel;
                end
            end
        end else if (write_tag_array !== 1'b0) begin
            flag("tag_without_write", {31'h0, write_tag_array});
        end
        if (fsm_busy === 1'b1) busy_cnt++;
        @(posedge clk);
        #1;
        rel++;
    endtask

    task automatic run_fill(input vec_t e);
        rel       = 0;
        busy_cnt  = 0;
        req_first = -1;
        wr_first  = -1;
        tag_rel   = -1;
        tag_seen  = 1'b0;
        irregular = e.irregular;
        for (int i = 0; i < 8; i++) begin
            exp_addr_q.push_back(e.exp_base + 16'(2 * i));
            exp_sel_q.push_back(i);
        end
        chk("busy_before_miss", {31'h0, fsm_busy}, 32'd0);
        miss_detected = 1'b1;
        miss_address  = e.miss_addr;
        cycle_check();
        miss_detected = 1'b0;
        while (!tag_seen && rel < 200) begin
            if (rel == e.mid_rel) begin
                miss_detected = 1'b1;
                miss_address  = 16'h0400;
            end
            chk("busy_in_fill", {31'h0, fsm_busy}, 32'd1);
            cycle_check();
            miss_detected = 1'b0;
        end
        if (!tag_seen) flag("fill_timeout", rel);
        chk("requests_left", exp_addr_q.size(), 32'd0);
        chk("writes_left", exp_sel_q.size(), 32'd0);
        chk("first_request_rel", req_first, 32'd1);
        if (e.exp_busy != 0) begin
            chk("busy_cycles", busy_cnt, e.exp_busy);
            chk("first_write_rel", wr_first, e.exp_wr_first);
            chk("tag_rel", tag_rel, e.exp_tag_rel);
        end
        exp_addr_q.delete();
        exp_sel_q.delete();
    endtask

    initial begin
        tbl[0] = '{16'h1234, 1'b0, 0,  16'h1230, 11, 4, 11};
        tbl[1] = '{16'hFFFF, 1'b0, 0,  16'hFFF0, 11, 4, 11};
        tbl[2] = '{16'h0200, 1'b0, 3,  16'h0200, 11, 4, 11};
        tbl[3] = '{16'h0010, 1'b0, 0,  16'h0010, 11, 4, 11};
        tbl[4] = '{16'h5678, 1'b0, 11, 16'h5670, 11, 4, 11};
        tbl[5] = '{16'h9ABC, 1'b1, 0,  16'h9AB0, 0,  0, 0};
        tbl[6] = '{16'h000F, 1'b0, 0,  16'h0000, 11, 4, 11};

        rst               = 1'b1;
        miss_detected     = 1'b0;
        miss_address      = 16'h0;
        memory_data_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_fsm_busy",         {31'h0, fsm_busy},         32'd0);
        chk("rst_mem_read_en",      {31'h0, mem_read_en},      32'd0);
        chk("rst_memory_address",   {16'h0, memory_address},   32'd0);
        chk("rst_write_data_array", {31'h0, write_data_array}, 32'd0);
        chk("rst_fill_word_sel",    {29'h0, fill_word_sel},    32'd0);
        chk("rst_write_tag_array",  {31'h0, write_tag_array},  32'd0);

        // Consecutive entries are back-to-back: each new miss lands in the first idle cycle.
        for (int k = 0; k < 7; k++) begin
            run_fill(tbl[k]);
        end

        // Reset asserted in cycle 5 of a fill of 0x0300.
        irregular = 1'b0;
        rel       = 0;
        busy_cnt  = 0;
        req_first = -1;
        wr_first  = -1;
        tag_seen  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_addr_q.push_back(16'h0300 + 16'(2 * i));
            exp_sel_q.push_back(i);
        end
        miss_detected = 1'b1;
        miss_address  = 16'h0300;
        cycle_check();
        miss_detected = 1'b0;
        for (int c = 1; c <= 4; c++) cycle_check();
        rst = 1'b1;
        cycle_check();
        rst = 1'b0;
        exp_addr_q.delete();
        exp_sel_q.delete();
        chk("rstmid_fsm_busy",         {31'h0, fsm_busy},         32'd0);
        chk("rstmid_mem_read_en",      {31'h0, mem_read_en},      32'd0);
        chk("rstmid_memory_address",   {16'h0, memory_address},   32'd0);
        chk("rstmid_write_data_array", {31'h0, write_data_array}, 32'd0);
        chk("rstmid_fill_word_sel",    {29'h0, fill_word_sel},    32'd0);
        chk("rstmid_write_tag_array",  {31'h0, write_tag_array},  32'd0);
        busy_cnt = 0;
        for (int c = 0; c < 10; c++) cycle_check();
        chk("rstmid_busy_after", busy_cnt, 32'd0);
        chk("rstmid_returns_drained", mem_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller between the pipelined CPU's cache lookup logic and the 4-cycle multi-cycle main memory. On an I-cache or D-cache miss it fetches the 8-word (16-byte) block containing the missing address, issuing one word request per cycle. It steers each returned word into the data array, then writes the tag. While it works it holds `fsm_busy` high, and the CPU uses that signal as its memory-stall input.

## Interface
- `ADDR_W`, 16: byte-address width.
- `WORDS_PER_BLOCK`, 8: 16-bit words per cache block; must be a power of two.
- `OFF_W`, 3: log2(`WORDS_PER_BLOCK`); word-select width.

Ports. One clock; reset is synchronous and active-high.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `miss_detected`, in, 1: lookup missed this cycle; sampled only in IDLE.
- `miss_address`, in, `ADDR_W`: byte address of the missing access; sampled with `miss_detected`.
- `memory_data_valid`, in, 1: main memory returns one word this cycle.
- `fsm_busy`, out, 1: fill in progress; stalls the pipeline.
- `mem_read_en`, out, 1: issue a read request to memory this cycle.
- `memory_address`, out, `ADDR_W`: request address, valid when `mem_read_en` = 1.
- `write_data_array`, out, 1: write the current `memory_data` word into the data array.
- `fill_word_sel`, out, `OFF_W`: word offset inside the block for that data-array write.
- `write_tag_array`, out, 1: write the tag and set the valid bit for the block.

## Operation
- States: IDLE and FILL.
- In IDLE, when `miss_detected` = 1 at the clock edge:
  - latch `base` = `miss_address` with bits [3:0] cleared;
  - clear `req_cnt` and `ret_cnt`;
  - go to FILL.
- In FILL, issuing requests:
  - `mem_read_en` = 1 while `req_cnt` < 8.
  - `memory_address` = `base` + 2·`req_cnt`.
  - `req_cnt` increments each cycle. It saturates at 8, after which `mem_read_en` = 0.
- In FILL, collecting returns. On each `memory_data_valid` = 1:
  - `write_data_array` = 1 and `fill_word_sel` = `ret_cnt`;
  - `ret_cnt` increments.
- Completion:
  - In the cycle of the 8th valid (`ret_cnt` = 7 && `memory_data_valid`), `write_tag_array` = 1 together with `write_data_array`.
  - The next state is IDLE.
- `fsm_busy` = 1 exactly when the state is FILL.
- Address arithmetic is 16-bit unsigned. The block is aligned, so there is no carry out of bit 3. For example, `base` = 0xFFF0 issues 0xFFF0 through 0xFFFE.
- Boundary cases:
  - `miss_detected` during FILL is ignored, and `miss_address` is not re-latched.
  - `memory_data_valid` in IDLE produces no writes.
  - Valids beyond the 8th cannot occur within a fill; the FSM has already left FILL.
  - Valid may arrive during the request phase. Both counters advance independently in the same cycle.
  - If the 8th valid arrives in a cycle where `miss_detected` = 1, the new miss is not accepted. The state is still FILL in that cycle, and it takes effect from the next IDLE cycle.
- Reset mid-fill: next state is IDLE, counters are 0, and all outputs are 0. In-flight memory returns arriving later are ignored.

## Timing
- Reset values: `fsm_busy`, `mem_read_en`, `write_data_array` and `write_tag_array` = 0; `memory_address` = 0x0000; `fill_word_sel` = 0.
- Miss sampled at edge E0. `fsm_busy` and `mem_read_en` go high in cycle 1. Requests occupy cycles 1–8.
- With 4-cycle memory, valids arrive in cycles 4–11. The tag write is in cycle 11, and `fsm_busy` is low from cycle 12. Busy therefore lasts 11 cycles.
- Requests are issued unconditionally, one per cycle. There is no backpressure from memory.
- `write_data_array`, `fill_word_sel` and `write_tag_array` are combinational from state, `ret_cnt` and `memory_data_valid`. They are valid in the same cycle as the returned word.
- Back-to-back misses: a miss presented in the first IDLE cycle after a fill (cycle 12) makes `fsm_busy` high again in cycle 13.

## Structure
- Shared cache package holds:
  - `WORDS_PER_BLOCK`, `OFF_W` and the block-offset mask 0xFFF0;
  - the FSM state encoding (IDLE = 0, FILL = 1).
- One sub-module, `fill_counter`: a saturating up-counter with synchronous clear and enable and a `done` flag.
  - It is instantiated twice, once for `req_cnt` (saturating at 8) and once for `ret_cnt`.
- Requests are issued one per cycle; there is no data buffering.

## Test plan
- Fill, base case:
  - Stimulus: reset, then a miss at 0x1234, with a 4-cycle memory model.
  - Addresses: 0x1230, 0x1232, …, 0x123E on cycles 1–8.
  - Writes: `fill_word_sel` 0–7 on cycles 4–11, with `write_tag_array` only on cycle 11.
  - `fsm_busy` is high in cycles 1–11.
- Miss at 0xFFFF:
  - Addresses run 0xFFF0–0xFFFE.
  - No address wraps to 0x0000.
- Extra miss mid-fill:
  - `miss_detected` pulsed with 0x0400 during a fill of 0x0200.
  - The fill completes for 0x0200 only, and no requests to 0x0400 are issued.
- Reset mid-fill:
  - `rst` asserted in cycle 5 of a fill.
  - In cycle 6 all outputs are 0 and the state is IDLE.
  - Later valids produce no `write_data_array`.
- Back-to-back misses:
  - A second miss at 0x0010 presented in the first IDLE cycle after a fill.
  - `fsm_busy` is high the next cycle and the first request is to 0x0010.
- Irregular memory timing:
  - Valids spaced irregularly, with gaps, after all 8 requests have gone out.
  - The FSM stays in FILL until the 8th valid, with offsets still 0–7 in order.
